// File: rtl/subcor_pipe_nl.sv
// rtl/subcor_pipe_nl.sv - multi-lane 3-stage (digit - correction) mod MODULUS pipeline
// Optional: define SUBCOR_RANGE_CHK_EN to build the sticky digit >= MODULUS range check.
module subcor_pipe_nl #(
  parameter int DATA_WIDTH    = 18,
  parameter int MODULUS       = 177147,
  parameter int DIGIT_CORRECT = 33343,
  parameter int LANES         = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] digit_in,
  input  logic [LANES*2-1:0]          sign_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] result,
  output logic [LANES-1:0]            wrap_out,
  output logic                        err_sticky
);

  localparam logic [DATA_WIDTH-1:0] CORR_0 = '0;
  localparam logic [DATA_WIDTH-1:0] CORR_1 = DATA_WIDTH'(DIGIT_CORRECT);
  localparam logic [DATA_WIDTH-1:0] CORR_2 = DATA_WIDTH'((2 * DIGIT_CORRECT) % MODULUS);
  localparam logic [DATA_WIDTH-1:0] CORR_3 = DATA_WIDTH'(MODULUS - DIGIT_CORRECT);
  localparam logic [DATA_WIDTH-1:0] MOD_W  = DATA_WIDTH'(MODULUS);

  logic adv;
  logic accept;
  logic v1;
  logic v2;

  // Single global advance: bubbles are kept, so every stage shifts together.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] corr;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] c_q;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] d_q;
    logic [DATA_WIDTH-1:0] dm_q;
    logic                  neg_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  wrap_q;

    always_comb begin
      corr = CORR_0;
      case (sign_in[2*i +: 2])
        2'b01:   corr = CORR_1;
        2'b10:   corr = CORR_2;
        2'b11:   corr = CORR_3;
        default: corr = CORR_0;
      endcase
    end

    // The extra top bit of diff is the borrow that selects the add-back path.
    assign diff = {1'b0, a_q} - {1'b0, c_q};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        a_q    <= '0;
        c_q    <= '0;
        d_q    <= '0;
        dm_q   <= '0;
        neg_q  <= 1'b0;
        res_q  <= '0;
        wrap_q <= 1'b0;
      end else if (adv) begin
        if (accept) begin
          a_q <= digit_in[i*DATA_WIDTH +: DATA_WIDTH];
          c_q <= corr;
        end
        if (v1) begin
          d_q   <= diff[DATA_WIDTH-1:0];
          dm_q  <= diff[DATA_WIDTH-1:0] + MOD_W;
          neg_q <= diff[DATA_WIDTH];
        end
        if (v2) begin
          res_q  <= neg_q ? dm_q : d_q;
          wrap_q <= neg_q;
        end
      end
    end

    assign result[i*DATA_WIDTH +: DATA_WIDTH] = res_q;
    assign wrap_out[i]                        = wrap_q;
  end

`ifdef SUBCOR_RANGE_CHK_EN
  logic [LANES-1:0] lane_bad;

  for (genvar j = 0; j < LANES; j++) begin : g_range
    assign lane_bad[j] = digit_in[j*DATA_WIDTH +: DATA_WIDTH] >= MOD_W;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= 1'b0;
    end else if (accept && |lane_bad) begin
      err_sticky <= 1'b1;
    end
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule
